fifo_write_arbiter: RTL and testbench
=====================================

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters; fixed at 4 in this revision.
REQ-002 Parameter DATA_W, 8, data width per requester and of the FIFO write port.
REQ-003 Parameter MAX_BURST, 4, max consecutive beats per grant when burst lock is enabled; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req  input  4  per-requester beat request; held with data until granted.
REQ-007 req_data  input  32  requester i data at bits [8i+7:8i].
REQ-008 fifo_full  input  1  full flag from the FIFO write port.
REQ-009 gnt  output  4  one-hot, combinational; gnt[i]=1 means requester i's beat is accepted at this edge.
REQ-010 fifo_write_en  output  1  combinational, equals OR of gnt.
REQ-011 fifo_write_data  output  8  combinational, req_data slice of the granted requester; 0 when no grant.
REQ-012 locked  output  1  registered; 1 while in state BURST.
REQ-013 beat_total  output  16  registered count of accepted beats; wraps 0xFFFF->0x0000.

Function
REQ-014 Beat accepted iff gnt[i]=1 at a rising clk edge; zero-cycle latency from req to fifo_write_en.
REQ-015 gnt SHALL be 0 whenever fifo_full=1; state, rr_ptr, beat counter then hold.
REQ-016 At most one gnt bit high; gnt[i] never high unless req[i]=1.
REQ-017 State machine: IDLE, BURST; registered rr_ptr (2 bits), owner (2 bits), beat_cnt (4 bits).
REQ-018 IDLE: winner = first i with req[i]=1 scanning rr_ptr, rr_ptr+1, ... mod 4; grant winner if fifo_full=0.
REQ-019 IDLE grant with MAX_BURST>1: owner<=winner, beat_cnt<=1, go BURST; with MAX_BURST=1: rr_ptr<=winner+1 mod 4, stay IDLE.
REQ-020 BURST, fifo_full=0, req[owner]=1: grant owner, beat_cnt+1; if that reaches MAX_BURST, rr_ptr<=owner+1 mod 4, go IDLE.
REQ-021 BURST, req[owner]=0: no grant this cycle (one-cycle bubble), rr_ptr<=owner+1 mod 4, go IDLE.
REQ-022 BURST, fifo_full=1: hold BURST, no grant, beat_cnt unchanged; burst resumes when full clears.
REQ-023 Other requesters' req are ignored while in BURST.
REQ-024 beat_total increments by 1 on every accepted beat.

Reset
REQ-025 While rst_n=0: state IDLE, rr_ptr=0, owner=0, beat_cnt=0, beat_total=0, locked=0, gnt=0, fifo_write_en=0, fifo_write_data=0.
REQ-026 Reset mid-burst aborts the burst; first grant after release follows rr_ptr=0 priority.

Configuration
REQ-027 Macro FIFO_ARB_BURST_LOCK_EN defined: behaviour per REQ-017..REQ-023.
REQ-028 Macro undefined: BURST state absent, locked tied 0, every grant from IDLE with rr_ptr<=winner+1 mod 4 (pure per-beat round-robin); MAX_BURST ignored.

Verification
REQ-029 Reset, req=4'b0001, data0=0x11, fifo_full=0 -> gnt=0001, write_data=0x11 each cycle, 4 beats then rr_ptr=1 (burst mode), beat_total=4.
REQ-030 req=4'b1111 held, burst mode, MAX_BURST=4 -> grant order 0,0,0,0,1,1,1,1,2,... ; per-beat mode -> 0,1,2,3,0,...
REQ-031 Burst owner 2, fifo_full=1 for 3 cycles mid-burst -> gnt=0, locked=1 held, beat_cnt frozen; burst completes after full clears with no lost or duplicated beats.
REQ-032 Burst owner 1 drops req after 2 beats -> one idle cycle, then grant to requester 2 if requesting, locked=0.
REQ-033 rst_n pulsed low mid-burst of owner 3 with req=4'b1010 -> immediate gnt=0, locked=0, beat_total=0; after release first grant to requester 1.
REQ-034 beat_total preset via 65535 beats -> next beat wraps to 0x0000.

Source files
------------

// File: rtl/fifo_write_arbiter_if.sv
// Write-side bundle shared by the requesters, the arbiter and the FIFO write port.
// slave = arbiter side, master = requester/FIFO side.
interface fifo_write_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic                      fifo_full;
   logic [NUM_REQ-1:0]        gnt;
   logic                      fifo_write_en;
   logic [DATA_W-1:0]         fifo_write_data;
   logic                      locked;
   logic [15:0]               beat_total;

   modport master (
      output req, req_data, fifo_full,
      input  gnt, fifo_write_en, fifo_write_data, locked, beat_total
   );

   modport slave (
      input  req, req_data, fifo_full,
      output gnt, fifo_write_en, fifo_write_data, locked, beat_total
   );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ requesters into one FIFO write port.
// Define FIFO_ARB_BURST_LOCK_EN to let a winner keep the port for up to MAX_BURST beats.
module fifo_write_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fifo_write_arbiter_if.slave  bus
);
   localparam int PTR_W = $clog2(NUM_REQ);
   typedef logic [PTR_W-1:0] idx_t;

   // Only the 4-requester, 1..15 beat configuration is supported.
   if (NUM_REQ != 4 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_unsupported_config
   end

   idx_t               rr_ptr_q, rr_ptr_d;
   logic [15:0]        beat_total_q, beat_total_d;
   logic [NUM_REQ-1:0] gnt_raw;
   logic [NUM_REQ-1:0] gnt;
   logic [DATA_W-1:0]  write_data;
   idx_t               winner;
   logic               winner_valid;
   idx_t               scan_idx;

   always_comb begin
      winner       = rr_ptr_q;
      winner_valid = 1'b0;
      scan_idx     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = rr_ptr_q + idx_t'(k);
         if (!winner_valid && bus.req[scan_idx]) begin
            winner       = scan_idx;
            winner_valid = 1'b1;
         end
      end
   end

`ifdef FIFO_ARB_BURST_LOCK_EN
   typedef enum logic {IDLE, BURST} state_t;
   localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

   state_t     state_q, state_d;
   idx_t       owner_q, owner_d;
   logic [3:0] beat_cnt_q, beat_cnt_d;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      beat_cnt_d = beat_cnt_q;
      rr_ptr_d   = rr_ptr_q;
      gnt_raw    = '0;
      case (state_q)
         IDLE: begin
            if (winner_valid && !bus.fifo_full) begin
               gnt_raw[winner] = 1'b1;
               if (MAX_BURST > 1) begin
                  owner_d    = winner;
                  beat_cnt_d = 4'd1;
                  state_d    = BURST;
               end else begin
                  rr_ptr_d = winner + idx_t'(1);
               end
            end
         end
         BURST: begin
            // A full FIFO freezes the burst; a dropped owner request ends it with a bubble.
            if (!bus.fifo_full) begin
               if (bus.req[owner_q]) begin
                  gnt_raw[owner_q] = 1'b1;
                  beat_cnt_d       = beat_cnt_q + 4'd1;
                  if (beat_cnt_q + 4'd1 == MAX_BURST_C) begin
                     rr_ptr_d   = owner_q + idx_t'(1);
                     beat_cnt_d = '0;
                     state_d    = IDLE;
                  end
               end else begin
                  rr_ptr_d   = owner_q + idx_t'(1);
                  beat_cnt_d = '0;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         owner_q    <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign bus.locked = (state_q == BURST);
`else
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      gnt_raw  = '0;
      if (winner_valid && !bus.fifo_full) begin
         gnt_raw[winner] = 1'b1;
         rr_ptr_d        = winner + idx_t'(1);
      end
   end

   assign bus.locked = 1'b0;
`endif

   // Grants are combinational, so they must be forced low while reset is held.
   assign gnt = gnt_raw & {NUM_REQ{rst_n}};

   always_comb begin
      write_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            write_data = bus.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign beat_total_d = beat_total_q + {15'd0, |gnt};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q     <= '0;
         beat_total_q <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         beat_total_q <= beat_total_d;
      end
   end

   assign bus.gnt             = gnt;
   assign bus.fifo_write_en   = |gnt;
   assign bus.fifo_write_data = write_data;
   assign bus.beat_total      = beat_total_q;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter against a beat-level reference model.
// Works with or without FIFO_ARB_BURST_LOCK_EN defined.
module tb_fifo_write_arbiter;
   localparam int NUM_REQ   = 4;
   localparam int DATA_W    = 8;
   localparam int MAX_BURST = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   fifo_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

   fifo_write_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .DATA_W   (DATA_W),
      .MAX_BURST(MAX_BURST)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: who may write next, and who currently holds the port.
   int          m_ptr;
   int          m_owner;
   int          m_cnt;
   logic        m_locked;
   logic [15:0] m_total;

   task automatic model_reset();
      m_ptr    = 0;
      m_owner  = 0;
      m_cnt    = 0;
      m_locked = 1'b0;
      m_total  = 16'd0;
   endtask

   function automatic logic [3:0] model_gnt(input logic [3:0] r, input logic f);
      logic [3:0] g;
      g = 4'b0000;
      if (f) return g;
      if (m_locked) begin
         if (r[m_owner]) g[m_owner] = 1'b1;
         return g;
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         if (r[(m_ptr + k) % NUM_REQ]) begin
            g[(m_ptr + k) % NUM_REQ] = 1'b1;
            return g;
         end
      end
      return g;
   endfunction

   function automatic logic [7:0] model_data(input logic [3:0] r, input logic [31:0] d,
                                             input logic f);
      logic [3:0] g;
      g = model_gnt(r, f);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (g[i]) return d[8*i +: 8];
      end
      return 8'h00;
   endfunction

   task automatic model_commit(input logic [3:0] r, input logic f);
      logic [3:0] g;
      int w;
      g = model_gnt(r, f);
      w = 0;
      for (int i = 0; i < NUM_REQ; i++) if (g[i]) w = i;
      if (f) return;
      if (g != 4'b0000) m_total = m_total + 16'd1;
`ifdef FIFO_ARB_BURST_LOCK_EN
      if (m_locked) begin
         if (r[m_owner]) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == MAX_BURST) begin
               m_locked = 1'b0;
               m_ptr    = (m_owner + 1) % NUM_REQ;
            end
         end else begin
            m_locked = 1'b0;
            m_ptr    = (m_owner + 1) % NUM_REQ;
         end
      end else if (g != 4'b0000) begin
         if (MAX_BURST > 1) begin
            m_locked = 1'b1;
            m_owner  = w;
            m_cnt    = 1;
         end else begin
            m_ptr = (w + 1) % NUM_REQ;
         end
      end
`else
      if (g != 4'b0000) m_ptr = (w + 1) % NUM_REQ;
`endif
   endtask

   task automatic drive(input logic [3:0] r, input logic [31:0] d, input logic f);
      @(negedge clk);
      bus.req       = r;
      bus.req_data  = d;
      bus.fifo_full = f;
      #1;
   endtask

   task automatic step(input logic [3:0] r, input logic f);
      @(posedge clk);
      model_commit(r, f);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n         = 1'b0;
      bus.req       = 4'b0000;
      bus.req_data  = 32'h0;
      bus.fifo_full = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      drive(4'b1111, 32'hA5C3_5A3C, 1'b0);
      checks++;
      if ({bus.gnt, bus.fifo_write_en, bus.fifo_write_data, bus.locked, bus.beat_total} !== 30'd0) begin
         errors++;
         $display("[TB] FAIL reset_outputs got gnt=%b en=%b data=%h locked=%b total=%h want all zero",
                  bus.gnt, bus.fifo_write_en, bus.fifo_write_data, bus.locked, bus.beat_total);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single_requester();
      logic [3:0] eg;
      logic [7:0] ed;
      do_reset();
      for (int n = 0; n < 4; n++) begin
         drive(4'b0001, 32'h0000_0011, 1'b0);
         eg = model_gnt(4'b0001, 1'b0);
         ed = model_data(4'b0001, 32'h0000_0011, 1'b0);
         checks++;
         if (bus.gnt !== 4'b0001 || bus.fifo_write_data !== 8'h11 || eg !== 4'b0001 || ed !== 8'h11) begin
            errors++;
            $display("[TB] FAIL single_beat n=%0d got gnt=%b data=%h want 0001/11", n, bus.gnt, bus.fifo_write_data);
         end
         step(4'b0001, 1'b0);
      end
      drive(4'b0000, 32'h0, 1'b0);
      checks++;
      if (bus.beat_total !== 16'd4 || bus.locked !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_total got total=%0d locked=%b want 4/0", bus.beat_total, bus.locked);
      end
      step(4'b0000, 1'b0);
   endtask

   task automatic test_round_robin();
      int idx;
      logic [3:0] want;
      logic [3:0] eg;
      do_reset();
      for (int n = 0; n < 16; n++) begin
`ifdef FIFO_ARB_BURST_LOCK_EN
         idx = (n / MAX_BURST) % NUM_REQ;
`else
         idx = n % NUM_REQ;
`endif
         want = 4'b0001 << idx;
         drive(4'b1111, 32'h4433_2211, 1'b0);
         eg = model_gnt(4'b1111, 1'b0);
         checks++;
         if (bus.gnt !== want || eg !== want) begin
            errors++;
            $display("[TB] FAIL rr_order n=%0d got gnt=%b want %b", n, bus.gnt, want);
         end
         checks++;
         if ({bus.locked, bus.beat_total} !== {m_locked, m_total}) begin
            errors++;
            $display("[TB] FAIL rr_state n=%0d got locked=%b total=%0d want %b/%0d",
                     n, bus.locked, bus.beat_total, m_locked, m_total);
         end
         step(4'b1111, 1'b0);
      end
   endtask

   task automatic test_full_stall();
      logic [3:0] rs [8] = '{4'b0100, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b0100, 4'b0100, 4'b0000};
      logic       fs [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic [3:0] eg;
      logic [7:0] ed;
      do_reset();
      for (int n = 0; n < 8; n++) begin
         drive(rs[n], 32'hDD_CC_BB_AA, fs[n]);
         eg = model_gnt(rs[n], fs[n]);
         ed = model_data(rs[n], 32'hDD_CC_BB_AA, fs[n]);
         checks++;
         if ({bus.gnt, bus.fifo_write_en, bus.fifo_write_data} !== {eg, |eg, ed}) begin
            errors++;
            $display("[TB] FAIL stall_grant n=%0d got %b/%b/%h want %b/%b/%h",
                     n, bus.gnt, bus.fifo_write_en, bus.fifo_write_data, eg, |eg, ed);
         end
         checks++;
         if ({bus.locked, bus.beat_total} !== {m_locked, m_total}) begin
            errors++;
            $display("[TB] FAIL stall_state n=%0d got locked=%b total=%0d want %b/%0d",
                     n, bus.locked, bus.beat_total, m_locked, m_total);
         end
         if (fs[n]) begin
            checks++;
            if (bus.gnt !== 4'b0000) begin
               errors++;
               $display("[TB] FAIL stall_no_grant n=%0d got gnt=%b want 0000", n, bus.gnt);
            end
         end
         step(rs[n], fs[n]);
      end
`ifdef FIFO_ARB_BURST_LOCK_EN
      checks++;
      if (bus.beat_total !== 16'd4 || bus.locked !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stall_beats got total=%0d locked=%b want 4/0", bus.beat_total, bus.locked);
      end
`endif
   endtask

   task automatic test_owner_drop();
      logic [3:0] rs [5] = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0000};
      logic [3:0] eg;
      do_reset();
      for (int n = 0; n < 5; n++) begin
         drive(rs[n], 32'h3322_1100, 1'b0);
         eg = model_gnt(rs[n], 1'b0);
         checks++;
         if (bus.gnt !== eg || bus.locked !== m_locked) begin
            errors++;
            $display("[TB] FAIL drop n=%0d got gnt=%b locked=%b want %b/%b", n, bus.gnt, bus.locked, eg, m_locked);
         end
`ifdef FIFO_ARB_BURST_LOCK_EN
         if (n == 2) begin
            checks++;
            if (bus.gnt !== 4'b0000) begin
               errors++;
               $display("[TB] FAIL drop_bubble got gnt=%b want 0000", bus.gnt);
            end
         end
         if (n == 3) begin
            checks++;
            if (bus.gnt !== 4'b0100 || bus.locked !== 1'b0) begin
               errors++;
               $display("[TB] FAIL drop_handover got gnt=%b locked=%b want 0100/0", bus.gnt, bus.locked);
            end
         end
`else
         if (n == 2) begin
            checks++;
            if (bus.gnt !== 4'b0100) begin
               errors++;
               $display("[TB] FAIL drop_handover got gnt=%b want 0100", bus.gnt);
            end
         end
`endif
         step(rs[n], 1'b0);
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      for (int n = 0; n < 2; n++) begin
         drive(4'b1000, 32'h7700_0000, 1'b0);
         step(4'b1000, 1'b0);
      end
      @(negedge clk);
      bus.req = 4'b1010;
      bus.req_data = 32'h7700_5500;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.gnt, bus.fifo_write_en, bus.locked, bus.beat_total} !== 22'd0) begin
         errors++;
         $display("[TB] FAIL midreset got gnt=%b en=%b locked=%b total=%0d want 0/0/0/0",
                  bus.gnt, bus.fifo_write_en, bus.locked, bus.beat_total);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus.gnt !== 4'b0010 || bus.fifo_write_data !== 8'h55 || model_gnt(4'b1010, 1'b0) !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL midreset_first got gnt=%b data=%h want 0010/55", bus.gnt, bus.fifo_write_data);
      end
      step(4'b1010, 1'b0);
   endtask

   task automatic test_random();
      logic [3:0]  r;
      logic [31:0] d;
      logic        f;
      logic [3:0]  eg;
      logic [7:0]  ed;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         r = 4'($urandom_range(0, 15));
         d = $urandom;
         f = ($urandom_range(0, 3) == 0);
         drive(r, d, f);
         eg = model_gnt(r, f);
         ed = model_data(r, d, f);
         checks++;
         if ({bus.gnt, bus.fifo_write_en, bus.fifo_write_data} !== {eg, |eg, ed}) begin
            errors++;
            $display("[TB] FAIL random_grant n=%0d req=%b full=%b got %b/%b/%h want %b/%b/%h",
                     n, r, f, bus.gnt, bus.fifo_write_en, bus.fifo_write_data, eg, |eg, ed);
         end
         checks++;
         if ({bus.locked, bus.beat_total} !== {m_locked, m_total}) begin
            errors++;
            $display("[TB] FAIL random_state n=%0d got locked=%b total=%0d want %b/%0d",
                     n, bus.locked, bus.beat_total, m_locked, m_total);
         end
         step(r, f);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      drive(4'b0001, 32'h0000_0001, 1'b0);
      repeat (65535) step(4'b0001, 1'b0);
      @(negedge clk);
      #1;
      checks++;
      if (bus.beat_total !== 16'hFFFF || m_total !== 16'hFFFF) begin
         errors++;
         $display("[TB] FAIL wrap_full got total=%h want FFFF", bus.beat_total);
      end
      step(4'b0001, 1'b0);
      @(negedge clk);
      #1;
      checks++;
      if (bus.beat_total !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL wrap_zero got total=%h want 0000", bus.beat_total);
      end
   endtask

   initial begin
      bus.req       = 4'b0000;
      bus.req_data  = 32'h0;
      bus.fifo_full = 1'b0;
      model_reset();
      test_reset();
      test_single_requester();
      test_round_robin();
      test_full_stall();
      test_owner_drop();
      test_reset_mid_burst();
      test_random();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5000000;
      $display("[TB] FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end
endmodule
